// File: rtl/axi_mem_slave.sv
// AXI4 memory responder with a byte-strobed 32-bit word array and independent read/write FSMs.
// Optional AXI_SLV_ERR_INJ_EN adds s_err_inj to force SLVERR on a whole transaction.
module axi_mem_slave #(
    parameter int ID_WIDTH   = 8,
    parameter int MEM_WORDS  = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef AXI_SLV_ERR_INJ_EN
    input  logic                  s_err_inj,
`endif
    input  logic [ID_WIDTH-1:0]   s_awid,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [ID_WIDTH-1:0]   s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [IW-1:0] TOP = IW'(MEM_WORDS);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    logic inj;
`ifdef AXI_SLV_ERR_INJ_EN
    assign inj = s_err_inj;
`else
    assign inj = 1'b0;
`endif

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    logic [31:0] mem [MEM_WORDS];

    // Precedence: unsupported burst / injected error, then out-of-range, then OKAY.
    function automatic logic [1:0] beat_resp(input logic [1:0] burst, input logic err,
                                             input logic [IW-1:0] idx);
        if (burst[1] || err) return SLVERR;
        else if (idx >= TOP) return DECERR;
        else return OKAY;
    endfunction

    function automatic logic [1:0] sev_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // ---------------- write path ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    wstate_t w_state_q, w_state_d;

    logic [ID_WIDTH-1:0] awid_q;
    logic [IW-1:0]       widx_q;
    logic [7:0]          awlen_q;
    logic [1:0]          awburst_q, bresp_q;
    logic                winj_q;
    logic [8:0]          wcnt_q;
    logic                aw_hs, w_hs, b_hs, mem_we;
    logic [1:0]          wbeat_resp, wlen_resp, bresp_d;

    assign aw_hs      = s_awvalid && s_awready;
    assign w_hs       = s_wvalid && s_wready;
    assign b_hs       = s_bvalid && s_bready;
    assign wbeat_resp = beat_resp(awburst_q, winj_q, widx_q);
    assign wlen_resp  = (s_wlast && (wcnt_q != {1'b0, awlen_q})) ? SLVERR : OKAY;
    assign bresp_d    = sev_max(bresp_q, sev_max(wbeat_resp, wlen_resp));
    assign mem_we     = w_hs && (wbeat_resp == OKAY);

    always_ff @(posedge clk) begin
        if (rst) w_state_q <= W_IDLE;
        else     w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && s_wlast) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        s_awready = !rst && (w_state_q == W_IDLE);
        s_wready  = !rst && (w_state_q == W_DATA);
        s_bvalid  = !rst && (w_state_q == W_RESP);
        s_bid     = awid_q;
        s_bresp   = bresp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awid_q    <= '0;
            widx_q    <= '0;
            awlen_q   <= '0;
            awburst_q <= '0;
            winj_q    <= 1'b0;
            wcnt_q    <= '0;
            bresp_q   <= OKAY;
        end else if (aw_hs) begin
            awid_q    <= s_awid;
            widx_q    <= s_awaddr[ADDR_WIDTH-1:2];
            awlen_q   <= s_awlen;
            awburst_q <= s_awburst;
            winj_q    <= inj;
            wcnt_q    <= '0;
            bresp_q   <= OKAY;
        end else if (w_hs) begin
            wcnt_q  <= wcnt_q + 9'd1;
            bresp_q <= bresp_d;
            if (awburst_q == 2'b01) widx_q <= widx_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) mem[widx_q[MW-1:0]][8*b +: 8] <= s_wdata[8*b +: 8];
        end
    end

    // ---------------- read path ----------------
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    rstate_t r_state_q, r_state_d;

    logic [ID_WIDTH-1:0] rid_q;
    logic [IW-1:0]       ridx_q, ld_idx;
    logic [7:0]          arlen_q, rcnt_q, ld_cnt, ld_len;
    logic [1:0]          arburst_q, ld_burst, ld_resp, rresp_q;
    logic                rinj_q, ld_inj, rlast_q;
    logic [31:0]         rdata_q;
    logic                ar_hs, r_hs, load;

    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = s_rvalid && s_rready;
    // A beat is loaded on AR acceptance and after every non-final R handshake.
    assign load  = ar_hs || (r_hs && !rlast_q);

    always_comb begin
        if (ar_hs) begin
            ld_idx   = s_araddr[ADDR_WIDTH-1:2];
            ld_burst = s_arburst;
            ld_inj   = inj;
            ld_len   = s_arlen;
            ld_cnt   = '0;
        end else begin
            ld_idx   = (arburst_q == 2'b01) ? ridx_q + IW'(1) : ridx_q;
            ld_burst = arburst_q;
            ld_inj   = rinj_q;
            ld_len   = arlen_q;
            ld_cnt   = rcnt_q + 8'd1;
        end
        ld_resp = beat_resp(ld_burst, ld_inj, ld_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state_q <= R_IDLE;
        else     r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_arready = !rst && (r_state_q == R_IDLE);
        s_rvalid  = !rst && (r_state_q == R_DATA);
        s_rid     = rid_q;
        s_rdata   = rdata_q;
        s_rresp   = rresp_q;
        s_rlast   = rlast_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rid_q     <= '0;
            ridx_q    <= '0;
            arlen_q   <= '0;
            arburst_q <= '0;
            rinj_q    <= 1'b0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            rlast_q   <= 1'b0;
        end else if (load) begin
            if (ar_hs) begin
                rid_q     <= s_arid;
                arlen_q   <= s_arlen;
                arburst_q <= s_arburst;
                rinj_q    <= inj;
            end
            ridx_q  <= ld_idx;
            rcnt_q  <= ld_cnt;
            rresp_q <= ld_resp;
            rlast_q <= (ld_cnt == ld_len);
            rdata_q <= (ld_resp == OKAY) ? mem[ld_idx[MW-1:0]] : 32'd0;
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: directed bursts, expected B/R beats queued and checked by a monitor.
module tb_axi_mem_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_awid, s_arid, s_bid, s_rid;
    logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
    logic [7:0]  s_awlen, s_arlen;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [3:0]  s_wstrb;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;

    always #5 clk = ~clk;

    axi_mem_slave #(.ID_WIDTH(8), .MEM_WORDS(1024), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
`ifdef AXI_SLV_ERR_INJ_EN
        .s_err_inj(1'b0),
`endif
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    typedef struct {logic [7:0] id; logic [1:0] resp;} b_t;
    typedef struct {logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_t;
    b_t bq[$];
    r_t rq[$];
    b_t be;
    r_t re, hold;
    logic stall = 1'b0;
    int tests = 0, fails = 0;
    logic [31:0] wd[16];
    logic [3:0]  ws[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic er(input logic [7:0] id, input logic [31:0] d, input logic [1:0] resp,
                      input logic last);
        r_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        rq.push_back(e);
    endtask

    // Monitor: pops expectations on every B/R handshake and checks R stability under stall.
    always @(negedge clk) begin
        if (rst) stall = 1'b0;
        else begin
            if (stall)
                chk("r_stable", 64'({s_rvalid, s_rid, s_rdata, s_rresp, s_rlast}),
                    64'({1'b1, hold.id, hold.data, hold.resp, hold.last}));
            if (s_bvalid && s_bready) begin
                if (bq.size() == 0) chk("unexpected_b", 64'(s_bid), 64'hFFFF);
                else begin
                    be = bq.pop_front();
                    chk("bid", 64'(s_bid), 64'(be.id));
                    chk("bresp", 64'(s_bresp), 64'(be.resp));
                end
            end
            if (s_rvalid && s_rready) begin
                if (rq.size() == 0) chk("unexpected_r", 64'(s_rdata), 64'hFFFF_FFFF_FFFF);
                else begin
                    re = rq.pop_front();
                    chk("rid", 64'(s_rid), 64'(re.id));
                    chk("rdata", 64'(s_rdata), 64'(re.data));
                    chk("rresp", 64'(s_rresp), 64'(re.resp));
                    chk("rlast", 64'(s_rlast), 64'(re.last));
                end
            end
            stall = s_rvalid && !s_rready;
            hold.id = s_rid; hold.data = s_rdata; hold.resp = s_rresp; hold.last = s_rlast;
        end
    end

    task automatic aw(input logic [7:0] id, input logic [31:0] a, input logic [7:0] len,
                      input logic [1:0] burst);
        @(posedge clk); #1;
        s_awid = id; s_awaddr = a; s_awlen = len; s_awburst = burst; s_awvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_awready) begin
                @(posedge clk); #1; s_awvalid = 1'b0; return;
            end
        end
        chk("aw_timeout", 64'(0), 64'(1));
        s_awvalid = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] d, input logic [3:0] st, input logic last);
        @(posedge clk); #1;
        s_wdata = d; s_wstrb = st; s_wlast = last; s_wvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_wready) begin
                @(posedge clk); #1; s_wvalid = 1'b0; return;
            end
        end
        chk("w_timeout", 64'(0), 64'(1));
        s_wvalid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] id, input logic [31:0] a, input logic [7:0] len,
                      input logic [1:0] burst, input int nb, input logic [1:0] exp_resp);
        b_t e;
        e.id = id; e.resp = exp_resp;
        bq.push_back(e);
        aw(id, a, len, burst);
        for (int i = 0; i < nb; i++) wbeat(wd[i], ws[i], i == nb - 1);
    endtask

    task automatic rd(input logic [7:0] id, input logic [31:0] a, input logic [7:0] len,
                      input logic [1:0] burst);
        @(posedge clk); #1;
        s_arid = id; s_araddr = a; s_arlen = len; s_arburst = burst; s_arvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_arready) begin
                @(posedge clk); #1; s_arvalid = 1'b0; return;
            end
        end
        chk("ar_timeout", 64'(0), 64'(1));
        s_arvalid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bq.size() == 0 && rq.size() == 0) return;
        end
        chk("drain_timeout", 64'(bq.size() + rq.size()), 64'(0));
        bq.delete(); rq.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        rst = 1'b1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_wlast = 0;
        s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awburst = 0;
        s_arid = 0; s_araddr = 0; s_arlen = 0; s_arburst = 0;
        s_wdata = 0; s_wstrb = 0; s_bready = 1; s_rready = 1;
        for (int i = 0; i < 16; i++) begin wd[i] = 0; ws[i] = 4'hF; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_bresp}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'({s_awready, s_arready}), 64'(2'b11));

        // 1: INCR write/read, then simultaneous AW and AR
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
        wr(8'h5A, 32'h100, 8'd3, 2'b01, 4, 2'b00);
        drain();
        for (int i = 0; i < 4; i++) er(8'h33, 32'hA0 + i, 2'b00, i == 3);
        rd(8'h33, 32'h100, 8'd3, 2'b01);
        drain();
        wd[0] = 32'h55AA55AA;
        er(8'h22, 32'hA0, 2'b00, 1'b1);
        fork
            wr(8'h11, 32'h200, 8'd0, 2'b01, 1, 2'b00);
            rd(8'h22, 32'h100, 8'd0, 2'b01);
        join
        drain();
        er(8'h23, 32'h55AA55AA, 2'b00, 1'b1);
        rd(8'h23, 32'h200, 8'd0, 2'b01);
        drain();

        // 2: strobe merge and FIXED bursts
        wd[0] = 32'hFFFFFFFF;
        wr(8'h01, 32'h40, 8'd0, 2'b01, 1, 2'b00);
        wd[0] = 32'h12345678; ws[0] = 4'b0101;
        wr(8'h01, 32'h40, 8'd0, 2'b01, 1, 2'b00);
        ws[0] = 4'hF;
        drain();
        er(8'h02, 32'hFF34FF78, 2'b00, 1'b1);
        rd(8'h02, 32'h40, 8'd0, 2'b01);
        wd[0] = 1; wd[1] = 2; wd[2] = 3;
        wr(8'h03, 32'h20, 8'd2, 2'b00, 3, 2'b00);
        drain();
        er(8'h04, 32'd3, 2'b00, 1'b0);
        er(8'h04, 32'd3, 2'b00, 1'b1);
        rd(8'h04, 32'h20, 8'd1, 2'b00);
        drain();

        // 3: R backpressure toggling every cycle
        for (int i = 0; i < 4; i++) er(8'h44, 32'hA0 + i, 2'b00, i == 3);
        s_rready = 1'b0;
        rd(8'h44, 32'h100, 8'd3, 2'b01);
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) chk("rvalid_latency", 64'(s_rvalid), 64'(1));
            if (s_rvalid && s_rready && s_rlast) begin got = 1'b1; break; end
            @(posedge clk); #1 s_rready = ~s_rready;
        end
        chk("t3_last_seen", 64'(got), 64'(1));
        @(negedge clk);
        chk("t3_arready_after_last", 64'({s_arready, s_rvalid}), 64'(2'b10));
        chk("t3_all_beats", 64'(rq.size()), 64'(0));
        s_rready = 1'b1;

        // 4: decode errors, unsupported burst, no wrap past the array top
        wd[0] = 32'hCAFE0000;
        wr(8'h06, 32'h0, 8'd0, 2'b01, 1, 2'b00);
        wd[0] = 32'hDEADBEEF;
        wr(8'h07, 32'h1000, 8'd0, 2'b01, 1, 2'b11);
        wd[0] = 32'h11111111;
        wr(8'h08, 32'h0, 8'd0, 2'b10, 1, 2'b10);
        wd[0] = 32'h0C0C0C0C; wd[1] = 32'h0D0D0D0D;
        wr(8'h09, 32'hFFC, 8'd1, 2'b01, 2, 2'b11);
        drain();
        er(8'h10, 32'hCAFE0000, 2'b00, 1'b1);
        rd(8'h10, 32'h0, 8'd0, 2'b01);
        er(8'h12, 32'h0, 2'b11, 1'b1);
        rd(8'h12, 32'h1000, 8'd0, 2'b01);
        er(8'h13, 32'h0, 2'b10, 1'b0);
        er(8'h13, 32'h0, 2'b10, 1'b1);
        rd(8'h13, 32'h0, 8'd1, 2'b10);
        er(8'h14, 32'h0C0C0C0C, 2'b00, 1'b0);
        er(8'h14, 32'h0, 2'b11, 1'b1);
        rd(8'h14, 32'hFFC, 8'd1, 2'b01);
        drain();

        // 5: early wlast, next AW still accepted; reset mid read burst
        wd[0] = 32'h77000000; wd[1] = 32'h77000001; wd[2] = 32'h77000002;
        wr(8'h0A, 32'h300, 8'd3, 2'b01, 3, 2'b10);
        wd[0] = 32'h00000012;
        wr(8'h0B, 32'h300, 8'd0, 2'b01, 1, 2'b00);
        drain();
        er(8'h0C, 32'h12, 2'b00, 1'b0);
        er(8'h0C, 32'h77000001, 2'b00, 1'b1);
        rd(8'h0C, 32'h300, 8'd1, 2'b01);
        drain();
        s_rready = 1'b0;
        rd(8'h0D, 32'h100, 8'd3, 2'b01);
        @(negedge clk);
        chk("rst_pre_rvalid", 64'(s_rvalid), 64'(1));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_rvalid", 64'({s_rvalid, s_arready}), 64'(0));
        @(posedge clk); #1 rst = 1'b0; s_rready = 1'b1;
        @(negedge clk);
        chk("rst_exit_ready", 64'({s_arready, s_awready, s_rvalid}), 64'(3'b110));
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("no_beats_after_rst", 64'(s_rvalid), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
